// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control: combinational RV32I op decode plus an iterative
// RV32M multiply/divide sequencer that stalls the pipeline while busy.
module alu_muldiv_ctrl #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 5,
  parameter int ENABLE_M   = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic [1:0]            iALUOp,
  input  logic [2:0]            iFunct3,
  input  logic [6:0]            iFunct7,
  input  logic                  iValid,
  input  logic                  iFlush,
  input  logic [XLEN-1:0]       iA,
  input  logic [XLEN-1:0]       iB,
  output logic [ALU_CTRL_W-1:0] oALUControl,
  output logic [XLEN-1:0]       oMDResult,
  output logic                  oMDValid,
  output logic                  oStall
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ANY = 2'b10;
  localparam logic [1:0] OP_IMM = 2'b11;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = ALU_CTRL_W'(4);
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = ALU_CTRL_W'(5);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = ALU_CTRL_W'(9);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_a;      // multiplicand / divisor magnitude
  logic [XLEN-1:0] r_hi;     // product high / partial remainder / special result
  logic [XLEN-1:0] r_lo;     // multiplier -> product low / dividend -> quotient
  logic [2:0]      r_f3;
  logic            r_neg;
  logic            r_special;
  logic            r_kill;   // flush seen last cycle: refuse new M ops this cycle

  // Base op for funct3 values whose decode is shared by OP and OP-IMM
  function automatic logic [ALU_CTRL_W-1:0] f3_op(input logic [2:0] f3);
    case (f3)
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b110:  f3_op = ALU_OR;
      3'b111:  f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  endfunction

  // Single-cycle ALU op decode; unlisted encodings fall back to ADD
  always_comb begin
    oALUControl = ALU_ADD;
    case (iALUOp)
      OP_SUB: oALUControl = ALU_SUB;
      OP_ANY: begin
        case (iFunct3)
          3'b000: if (iFunct7 == F7_ALT) oALUControl = ALU_SUB;
          3'b101: begin
            if (iFunct7 == F7_BASE)     oALUControl = ALU_SRL;
            else if (iFunct7 == F7_ALT) oALUControl = ALU_SRA;
          end
          default: if (iFunct7 == F7_BASE) oALUControl = f3_op(iFunct3);
        endcase
      end
      OP_IMM: begin
        case (iFunct3)
          3'b000:  oALUControl = ALU_ADD;
          3'b101:  oALUControl = iFunct7[5] ? ALU_SRA : ALU_SRL;
          default: oALUControl = f3_op(iFunct3);
        endcase
      end
      default: oALUControl = ALU_ADD;
    endcase
  end

  // M-op detection and operand preparation (magnitudes, signs, special divides)
  logic            w_mop, w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic            w_div0, w_ovf, w_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec;

  assign w_mop    = (ENABLE_M != 0) && iValid && (iALUOp == OP_ANY) && (iFunct7 == F7_MULD);
  assign w_accept = w_mop && !iFlush && !r_kill;
  assign w_is_div = iFunct3[2];
  // MUL/MULH/MULHSU take rs1 signed; MUL/MULH take rs2 signed; DIV/REM both signed
  assign w_a_sgn  = w_is_div ? ~iFunct3[0] : (iFunct3[1:0] != 2'b11);
  assign w_b_sgn  = w_is_div ? ~iFunct3[0] : ~iFunct3[1];
  assign w_a_neg  = w_a_sgn & iA[XLEN-1];
  assign w_b_neg  = w_b_sgn & iB[XLEN-1];
  assign w_a_mag  = w_a_neg ? -iA : iA;
  assign w_b_mag  = w_b_neg ? -iB : iB;
  assign w_div0   = w_is_div && (iB == '0);
  assign w_ovf    = w_is_div && !iFunct3[0] && (iA == {1'b1, {(XLEN-1){1'b0}}}) && (iB == '1);
  // Remainder sign follows the dividend; everything else is the operand-sign xor
  assign w_neg    = (w_is_div && iFunct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_spec   = w_div0 ? (iFunct3[1] ? iA : '1) : (iFunct3[1] ? '0 : iA);

  // Iteration datapath: shift-add multiply step and restoring divide step
  logic [XLEN:0] w_msum, w_dsh, w_dsub;
  logic          w_dge;

  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_dsh  = {r_hi, r_lo[XLEN-1]};
  assign w_dsub = w_dsh - {1'b0, r_a};
  assign w_dge  = ~w_dsub[XLEN];

  // Next-state logic; flush overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_div0 || w_ovf) ? S_DONE : (w_is_div ? S_DIV : S_MUL);
      S_MUL:  if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DIV:  if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (iFlush) w_next = S_IDLE;
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Operand latch and per-cycle iteration
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_special <= 1'b0;
      r_kill    <= 1'b0;
    end else begin
      r_kill <= iFlush;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_cnt     <= CW'(XLEN);
          r_f3      <= iFunct3;
          r_neg     <= w_neg;
          r_special <= w_div0 || w_ovf;
          r_a       <= w_is_div ? w_b_mag : w_a_mag;
          r_lo      <= w_is_div ? w_a_mag : w_b_mag;
          r_hi      <= (w_div0 || w_ovf) ? w_spec : '0;
        end
        S_MUL: begin
          r_cnt <= r_cnt - CW'(1);
          r_hi  <= w_msum[XLEN:1];
          r_lo  <= {w_msum[0], r_lo[XLEN-1:1]};
        end
        S_DIV: begin
          r_cnt <= r_cnt - CW'(1);
          r_hi  <= w_dge ? w_dsub[XLEN-1:0] : w_dsh[XLEN-1:0];
          r_lo  <= {r_lo[XLEN-2:0], w_dge};
        end
        default: ;
      endcase
    end
  end

  // Sign correction and result selection, presented only in DONE
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_q, w_r, w_final;

  assign w_prod  = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
  assign w_q     = r_neg ? -r_lo : r_lo;
  assign w_r     = r_neg ? -r_hi : r_hi;
  assign w_final = r_special ? r_hi :
                   r_f3[2]   ? (r_f3[1] ? w_r : w_q) :
                   (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  assign oMDValid  = (r_state == S_DONE);
  assign oMDResult = oMDValid ? w_final : '0;
  assign oStall    = iRST && (((r_state == S_IDLE) && w_accept) ||
                              (r_state == S_MUL) || (r_state == S_DIV));

endmodule
